pwm_multi_channel: RTL and testbench
====================================

PWM_MULTI_CHANNEL -- requirements
Module: pwm_multi_channel

Interface
REQ-001 Parameter NCH, default 4: number of PWM channels (1..16).
REQ-002 Parameter CW, default 16: counter, period and pulse width in bits.
REQ-003 Parameter DW, default 8: output amplitude width per channel.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 enable  input  1  run request; low forces IDLE.
REQ-007 period  input  CW  period length in clk cycles.
REQ-008 pulse  input  NCH*CW  per-channel high-phase length; channel n at bits [n*CW +: CW].
REQ-009 size  input  NCH*DW  per-channel amplitude driven during high phase.
REQ-010 polarity  input  NCH  per-channel inversion; 1 swaps high and low phases.
REQ-011 update  input  1  single-cycle strobe requesting a shadow-to-active load at the next period boundary.
REQ-012 pwm  output  NCH*DW  registered per-channel PWM amplitude.
REQ-013 period_end  output  1  one-cycle pulse on each counter wrap.
REQ-014 update_pending  output  1  high while an update request awaits a period boundary.

Function
REQ-015 The FSM SHALL have two states: IDLE and RUN.
REQ-016 In IDLE: counter = 0, pwm = 0, period_end = 0; enable=1 SHALL load all active registers from the inputs, clear update_pending, and enter RUN with counter = 0.
REQ-017 In RUN: counter SHALL increment by 1 per cycle and wrap to 0 when counter == period_a-1 (period_a = active period).
REQ-018 The wrap cycle SHALL assert period_end for exactly that cycle.
REQ-019 On a wrap cycle with update_pending=1 or update=1, active period/pulse/size/polarity SHALL load from the inputs sampled that cycle, and update_pending SHALL be 0 on the next cycle.
REQ-020 update=1 on a non-wrap cycle SHALL set update_pending=1 on the next cycle; repeated strobes SHALL have no additional effect.
REQ-021 In edge-aligned mode, channel n is in its high phase when counter < pulse_a[n].
REQ-022 pwm[n] SHALL equal size_a[n] in the high phase and 0 otherwise when polarity_a[n]=0, and the swapped assignment when polarity_a[n]=1.
REQ-023 pwm SHALL be registered: the value on cycle t+1 reflects the counter on cycle t (latency 1).
REQ-024 pulse_a[n] >= period_a SHALL give a permanent high phase; pulse_a[n] = 0 SHALL give a permanent low phase.
REQ-025 period_a of 0 or 1 SHALL hold counter at 0 and assert period_end every RUN cycle.
REQ-026 enable=0 in RUN SHALL enter IDLE next cycle: counter = 0, pwm = 0, and update_pending cleared.
REQ-027 All compare arithmetic SHALL be unsigned CW-bit, with no overflow at period = 2^CW-1.

Reset
REQ-028 While rstn=0: state = IDLE, counter = 0, all active registers = 0, pwm = 0, period_end = 0, update_pending = 0.
REQ-029 Reset asserted mid-period SHALL take effect immediately (asynchronous) and clear all registers listed in REQ-028.

Configuration
REQ-030 Macro PWM_CENTER_ALIGN_EN, when defined, SHALL add input center (1 bit).
REQ-031 With center=1, channel n SHALL be high when lo[n] <= counter < lo[n]+pulse_a[n], where lo[n] = (period_a-pulse_a[n])>>1 is computed at active-register load; center SHALL be captured with the other active registers.
REQ-032 Without the macro, the center port SHALL be absent and behaviour SHALL be edge-aligned only.

Verification
REQ-033 NCH=4, period=10, pulse={0,3,10,12}, size=8'hFF, polarity=0, enable at t0 -> ch0 always 0; ch1 high 3 of every 10 cycles; ch2 and ch3 always FF; period_end every 10 cycles.
REQ-034 Running at pulse=3, pulse changed to 7 with update mid-period -> update_pending=1 until the wrap; new duty starts from the following period with no partial period.
REQ-035 update asserted exactly on a wrap cycle -> load occurs at that wrap; update_pending never asserts.
REQ-036 polarity[1]=1, pulse=3, period=10 -> ch1 = 0 for 3 cycles and size for 7 cycles.
REQ-037 enable dropped mid-period, then rstn pulsed low mid-period -> pwm = 0 and counter = 0 on the next cycle and immediately on reset, respectively; re-enable restarts at count 0.
REQ-038 PWM_CENTER_ALIGN_EN defined, center=1, period=10, pulse=4 -> high phase spans counts 3..6.

Source files
------------

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: multi-channel PWM with shadowed period/pulse/size/polarity loaded at period boundaries.
// Optional center-aligned mode enabled by defining PWM_CENTER_ALIGN_EN (adds the center input).
module pwm_multi_channel #(
    parameter int NCH = 4,
    parameter int CW  = 16,
    parameter int DW  = 8
) (
    input  logic              clk,
    input  logic              rstn,
`ifdef PWM_CENTER_ALIGN_EN
    input  logic              center,
`endif
    input  logic              enable,
    input  logic [CW-1:0]     period,
    input  logic [NCH*CW-1:0] pulse,
    input  logic [NCH*DW-1:0] size,
    input  logic [NCH-1:0]    polarity,
    input  logic              update,
    output logic [NCH*DW-1:0] pwm,
    output logic              period_end,
    output logic              update_pending
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, period_q, period_d;
    logic [NCH*CW-1:0] pulse_q, pulse_d;
    logic [NCH*DW-1:0] size_q, size_d, pwm_q, pwm_d;
    logic [NCH-1:0] pol_q, pol_d, high;
    logic pend_q, pend_d, wrap, load;
    // periods of 0 or 1 wrap every cycle; avoids underflow of period_q-1
    assign wrap = state_q == RUN && (period_q <= CW'(1) || cnt_q == period_q - CW'(1));
    assign load = state_q == IDLE ? enable : enable && wrap && (pend_q || update);
    assign pwm = pwm_q;
    assign period_end = wrap;
    assign update_pending = pend_q;
`ifdef PWM_CENTER_ALIGN_EN
    logic center_q;
    logic [NCH*CW-1:0] lo_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            center_q <= 1'b0;
            lo_q     <= '0;
        end else if (load) begin
            center_q <= center;
            for (int n = 0; n < NCH; n++)
                lo_q[n*CW +: CW] <= pulse[n*CW +: CW] >= period ? '0 : (period - pulse[n*CW +: CW]) >> 1;
        end
    end
    always_comb begin
        high = '0;
        for (int n = 0; n < NCH; n++)
            high[n] = center_q ? cnt_q >= lo_q[n*CW +: CW] && cnt_q - lo_q[n*CW +: CW] < pulse_q[n*CW +: CW]
                               : cnt_q < pulse_q[n*CW +: CW];
    end
`else
    always_comb begin
        high = '0;
        for (int n = 0; n < NCH; n++)
            high[n] = cnt_q < pulse_q[n*CW +: CW];
    end
`endif
    always_comb begin
        state_d  = enable ? RUN : IDLE;
        cnt_d    = state_q == RUN && enable && !wrap ? cnt_q + CW'(1) : '0;
        period_d = load ? period : period_q;
        pulse_d  = load ? pulse : pulse_q;
        size_d   = load ? size : size_q;
        pol_d    = load ? polarity : pol_q;
        pend_d   = state_q == RUN && enable && !wrap && (pend_q || update);
        pwm_d    = '0;
        for (int n = 0; n < NCH; n++)
            pwm_d[n*DW +: DW] = state_q == RUN && enable && (high[n] ^ pol_q[n]) ? size_q[n*DW +: DW] : '0;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            pulse_q  <= '0;
            size_q   <= '0;
            pol_q    <= '0;
            pend_q   <= 1'b0;
            pwm_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            pulse_q  <= pulse_d;
            size_q   <= size_d;
            pol_q    <= pol_d;
            pend_q   <= pend_d;
            pwm_q    <= pwm_d;
        end
    end
endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb_pwm_multi_channel: scoreboard bench for pwm_multi_channel (NCH=4, CW=16, DW=8).
// Expected per-cycle outputs are queued as stimulus is set up and popped at each falling edge.
module tb_pwm_multi_channel;
    localparam int NCH = 4, CW = 16, DW = 8;
    logic clk = 1'b0, rstn = 1'b0, enable = 1'b0, update = 1'b0;
    logic [CW-1:0] period = '0;
    logic [NCH*CW-1:0] pulse = '0;
    logic [NCH*DW-1:0] size = '0;
    logic [NCH-1:0] polarity = '0;
    logic [NCH*DW-1:0] pwm;
    logic period_end, update_pending;
`ifdef PWM_CENTER_ALIGN_EN
    logic center = 1'b0;
`endif
    typedef struct packed {logic [NCH*DW-1:0] pwm; logic pe; logic up;} exp_t;
    exp_t q[$];
    exp_t e;
    int total = 0, bad = 0;

    pwm_multi_channel #(.NCH(NCH), .CW(CW), .DW(DW)) dut (
        .clk(clk), .rstn(rstn),
`ifdef PWM_CENTER_ALIGN_EN
        .center(center),
`endif
        .enable(enable), .period(period), .pulse(pulse), .size(size), .polarity(polarity),
        .update(update), .pwm(pwm), .period_end(period_end), .update_pending(update_pending)
    );

    always #5 clk = ~clk;

    function automatic logic [NCH*DW-1:0] f_pwm(int c, logic [NCH*CW-1:0] pul, logic [NCH-1:0] pol,
                                                logic [NCH*DW-1:0] sz, bit ctr, int t);
        logic [NCH*DW-1:0] r = '0;
        for (int n = 0; n < NCH; n++) begin
            int p = int'(pul[n*CW +: CW]);
            int lo = p >= t ? 0 : (t - p) / 2;
            bit hi = ctr ? (c >= lo && c < lo + p) : (c < p);
            if (hi ^ pol[n]) r[n*DW +: DW] = sz[n*DW +: DW];
        end
        return r;
    endfunction

    task automatic push_run(int n, int t, logic [NCH*CW-1:0] pa, logic [NCH*CW-1:0] pb, int sw,
                            logic [NCH-1:0] pol, logic [NCH*DW-1:0] sz, bit ctr);
        for (int j = 0; j < n; j++)
            q.push_back('{pwm: j == 0 ? '0 : f_pwm((j - 1) % t, j <= sw ? pa : pb, pol, sz, ctr, t),
                          pe: (j % t) == t - 1, up: 1'b0});
    endtask

    task automatic stop();
        enable = 1'b0;
        update = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        enable = 1'b1;
        period = 16'd10;
        pulse = {16'd5, 16'd5, 16'd5, 16'd5};
        size = '1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total += 3;
            if (pwm !== '0) begin bad++; $display("FAIL reset pwm got=%h want=0", pwm); end
            if (period_end !== 1'b0) begin bad++; $display("FAIL reset period_end got=%b want=0", period_end); end
            if (update_pending !== 1'b0) begin bad++; $display("FAIL reset update_pending got=%b want=0", update_pending); end
        end
        enable = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        period = 16'd10;
        pulse = {16'd12, 16'd10, 16'd3, 16'd0};
        size = '1;
        polarity = '0;
        push_run(25, 10, pulse, pulse, 1000, polarity, size, 1'b0);
        enable = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            e = q.pop_front();
            total += 3;
            if (pwm !== e.pwm) begin bad++; $display("FAIL basic pwm k=%0d got=%h want=%h", k, pwm, e.pwm); end
            if (period_end !== e.pe) begin bad++; $display("FAIL basic period_end k=%0d got=%b want=%b", k, period_end, e.pe); end
            if (update_pending !== e.up) begin bad++; $display("FAIL basic update_pending k=%0d got=%b want=%b", k, update_pending, e.up); end
        end
        stop();
    endtask

    task automatic test_polarity();
        period = 16'd10;
        pulse = {16'd5, 16'd0, 16'd3, 16'd20};
        size = {8'h44, 8'h33, 8'h22, 8'h11};
        polarity = 4'b0010;
        push_run(21, 10, pulse, pulse, 1000, polarity, size, 1'b0);
        enable = 1'b1;
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            e = q.pop_front();
            total += 3;
            if (pwm !== e.pwm) begin bad++; $display("FAIL polarity pwm k=%0d got=%h want=%h", k, pwm, e.pwm); end
            if (period_end !== e.pe) begin bad++; $display("FAIL polarity period_end k=%0d got=%b want=%b", k, period_end, e.pe); end
            if (update_pending !== e.up) begin bad++; $display("FAIL polarity update_pending k=%0d got=%b want=%b", k, update_pending, e.up); end
        end
        stop();
    endtask

    task automatic test_update_mid();
        logic [NCH*CW-1:0] pa = {16'd6, 16'd2, 16'd3, 16'd20};
        logic [NCH*CW-1:0] pb = {16'd6, 16'd2, 16'd7, 16'd20};
        period = 16'd10;
        pulse = pa;
        size = {8'h44, 8'h33, 8'h22, 8'h11};
        polarity = '0;
        push_run(25, 10, pa, pb, 10, polarity, size, 1'b0);
        for (int i = 5; i <= 9; i++) q[i].up = 1'b1;
        enable = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            e = q.pop_front();
            total += 3;
            if (pwm !== e.pwm) begin bad++; $display("FAIL update_mid pwm k=%0d got=%h want=%h", k, pwm, e.pwm); end
            if (period_end !== e.pe) begin bad++; $display("FAIL update_mid period_end k=%0d got=%b want=%b", k, period_end, e.pe); end
            if (update_pending !== e.up) begin bad++; $display("FAIL update_mid update_pending k=%0d got=%b want=%b", k, update_pending, e.up); end
            if (k == 4) begin pulse = pb; update = 1'b1; end
            if (k == 5) update = 1'b0;
        end
        stop();
    endtask

    task automatic test_update_on_wrap();
        logic [NCH*CW-1:0] pa = {16'd1, 16'd9, 16'd3, 16'd0};
        logic [NCH*CW-1:0] pb = {16'd4, 16'd9, 16'd5, 16'd2};
        period = 16'd10;
        pulse = pa;
        size = {8'h44, 8'h33, 8'h22, 8'h11};
        polarity = '0;
        push_run(25, 10, pa, pb, 10, polarity, size, 1'b0);
        enable = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            e = q.pop_front();
            total += 3;
            if (pwm !== e.pwm) begin bad++; $display("FAIL update_wrap pwm k=%0d got=%h want=%h", k, pwm, e.pwm); end
            if (period_end !== e.pe) begin bad++; $display("FAIL update_wrap period_end k=%0d got=%b want=%b", k, period_end, e.pe); end
            if (update_pending !== e.up) begin bad++; $display("FAIL update_wrap update_pending k=%0d got=%b want=%b", k, update_pending, e.up); end
            if (k == 9) begin pulse = pb; update = 1'b1; end
            if (k == 10) update = 1'b0;
        end
        stop();
    endtask

    task automatic test_enable_reset();
        period = 16'd10;
        pulse = {16'd6, 16'd0, 16'd3, 16'd20};
        size = {8'h44, 8'h33, 8'h22, 8'h11};
        polarity = '0;
        push_run(5, 10, pulse, pulse, 1000, polarity, size, 1'b0);
        q.push_back('{pwm: '0, pe: 1'b0, up: 1'b0});
        push_run(6, 10, pulse, pulse, 1000, polarity, size, 1'b0);
        q[10].up = 1'b1;
        q[11].up = 1'b1;
        enable = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            e = q.pop_front();
            total += 3;
            if (pwm !== e.pwm) begin bad++; $display("FAIL enable_drop pwm k=%0d got=%h want=%h", k, pwm, e.pwm); end
            if (period_end !== e.pe) begin bad++; $display("FAIL enable_drop period_end k=%0d got=%b want=%b", k, period_end, e.pe); end
            if (update_pending !== e.up) begin bad++; $display("FAIL enable_drop update_pending k=%0d got=%b want=%b", k, update_pending, e.up); end
            if (k == 4) enable = 1'b0;
            if (k == 5) enable = 1'b1;
            if (k == 9) update = 1'b1;
            if (k == 10) update = 1'b0;
        end
        #2 rstn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) #1; else @(negedge clk);
            total += 3;
            if (pwm !== '0) begin bad++; $display("FAIL async_reset pwm k=%0d got=%h want=0", k, pwm); end
            if (period_end !== 1'b0) begin bad++; $display("FAIL async_reset period_end k=%0d got=%b want=0", k, period_end); end
            if (update_pending !== 1'b0) begin bad++; $display("FAIL async_reset update_pending k=%0d got=%b want=0", k, update_pending); end
        end
        push_run(12, 10, pulse, pulse, 1000, polarity, size, 1'b0);
        rstn = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            e = q.pop_front();
            total += 3;
            if (pwm !== e.pwm) begin bad++; $display("FAIL after_reset pwm k=%0d got=%h want=%h", k, pwm, e.pwm); end
            if (period_end !== e.pe) begin bad++; $display("FAIL after_reset period_end k=%0d got=%b want=%b", k, period_end, e.pe); end
            if (update_pending !== e.up) begin bad++; $display("FAIL after_reset update_pending k=%0d got=%b want=%b", k, update_pending, e.up); end
        end
        stop();
    endtask

    task automatic test_short_period();
        pulse = {16'd0, 16'd1, 16'd5, 16'd0};
        size = {8'h44, 8'h33, 8'h22, 8'h11};
        polarity = 4'b1000;
        for (int p = 0; p < 2; p++) begin
            period = CW'(p);
            push_run(6, 1, pulse, pulse, 1000, polarity, size, 1'b0);
            enable = 1'b1;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                e = q.pop_front();
                total += 3;
                if (pwm !== e.pwm) begin bad++; $display("FAIL short_period p=%0d pwm k=%0d got=%h want=%h", p, k, pwm, e.pwm); end
                if (period_end !== e.pe) begin bad++; $display("FAIL short_period p=%0d period_end k=%0d got=%b want=%b", p, k, period_end, e.pe); end
                if (update_pending !== e.up) begin bad++; $display("FAIL short_period p=%0d update_pending k=%0d got=%b want=%b", p, k, update_pending, e.up); end
            end
            stop();
        end
    endtask

`ifdef PWM_CENTER_ALIGN_EN
    task automatic test_center();
        period = 16'd10;
        pulse = {16'd20, 16'd0, 16'd4, 16'd9};
        size = {8'h44, 8'h33, 8'h22, 8'h11};
        polarity = '0;
        center = 1'b1;
        push_run(21, 10, pulse, pulse, 1000, polarity, size, 1'b1);
        enable = 1'b1;
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            e = q.pop_front();
            total += 3;
            if (pwm !== e.pwm) begin bad++; $display("FAIL center pwm k=%0d got=%h want=%h", k, pwm, e.pwm); end
            if (period_end !== e.pe) begin bad++; $display("FAIL center period_end k=%0d got=%b want=%b", k, period_end, e.pe); end
            if (update_pending !== e.up) begin bad++; $display("FAIL center update_pending k=%0d got=%b want=%b", k, update_pending, e.up); end
        end
        center = 1'b0;
        stop();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_polarity();
        test_update_mid();
        test_update_on_wrap();
        test_enable_reset();
        test_short_period();
`ifdef PWM_CENTER_ALIGN_EN
        test_center();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
